mau_reliable_flowstate_ctrl: RTL and testbench

//  Owns the single write port of the reliable-send flowstate table (RPN counters, one per flow index).

---
 rtl/mau_reliable_flowstate_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mau_reliable_flowstate_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mau_reliable_flowstate_ctrl.sv
// -----------------------------------------------------------------------------
// mau_reliable_flowstate_ctrl
//
// Purpose:
//   Owns the single write port of the reliable-send flowstate table (one RPN
//   counter per flow index) and arbitrates it between three requesters with
//   fixed priority: datapath writeback > clear sweep > control-plane write.
//   Also sequences the table read port for control-plane reads.
//
// Build option:
//   MAU_RELIABLE_FLOWSTATE_CTRL_STATS_EN
//     defined   : stat_dp_defer_o counts cycles a pending cfg/clear write lost
//                 the port to a datapath write (saturating).
//     undefined : stat_dp_defer_o tied to 0, no counter flops.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dp_wr_valid_i/addr/data  datapath writeback (never back-pressured)
//   cfg_req_*_i / _ready_o   control-plane request (valid/ready handshake)
//   cfg_rsp_valid_o/rdata_o  1-cycle response pulse; rdata is 0 on writes
//   clear_start_i            pulse: start a full-table clear sweep
//   busy_o                   clear sweep in progress
//   tbl_wr_*_o               table RAM write port
//   tbl_rd_en_o/addr_o       table RAM read port (data returns 1 cycle later)
//   tbl_rd_data_i            table RAM read data
//   stat_dp_defer_o          deferred-write cycle counter
// -----------------------------------------------------------------------------
module mau_reliable_flowstate_ctrl #(
    parameter int FLOWSTATE_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter bit CLR_ON_RESET    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dp_wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]      dp_wr_addr_i,
    input  logic [FLOWSTATE_WIDTH-1:0] dp_wr_data_i,
    input  logic                       cfg_req_valid_i,
    output logic                       cfg_req_ready_o,
    input  logic                       cfg_req_write_i,
    input  logic [ADDR_WIDTH-1:0]      cfg_req_addr_i,
    input  logic [FLOWSTATE_WIDTH-1:0] cfg_req_wdata_i,
    output logic                       cfg_rsp_valid_o,
    output logic [FLOWSTATE_WIDTH-1:0] cfg_rsp_rdata_o,
    input  logic                       clear_start_i,
    output logic                       busy_o,
    output logic                       tbl_wr_en_o,
    output logic [ADDR_WIDTH-1:0]      tbl_wr_addr_o,
    output logic [FLOWSTATE_WIDTH-1:0] tbl_wr_data_o,
    output logic                       tbl_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      tbl_rd_addr_o,
    input  logic [FLOWSTATE_WIDTH-1:0] tbl_rd_data_i,
    output logic [31:0]                stat_dp_defer_o
);

    // state    | meaning
    // IDLE     | serving cfg requests; datapath writes pass straight through
    // RD_WAIT  | RAM read in flight; capture read data for the response
    // CLEAR    | sweeping zeros over the whole table, busy asserted
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

    localparam state_t                RST_STATE = CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = '1;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        clr_ptr_q, clr_ptr_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [FLOWSTATE_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The write/read port is driven combinationally so a datapath write lands
    // in the same cycle as its strobe. Everything is held at reset values while
    // rst is high so the RAM sees no traffic during reset.
    always_comb begin
        state_d         = state_q;
        clr_ptr_d       = clr_ptr_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = '0;
        cfg_req_ready_o = 1'b0;
        tbl_wr_en_o     = 1'b0;
        tbl_wr_addr_o   = '0;
        tbl_wr_data_o   = '0;
        tbl_rd_en_o     = 1'b0;
        tbl_rd_addr_o   = '0;

        if (!rst) begin
            if (dp_wr_valid_i) begin
                tbl_wr_en_o   = 1'b1;
                tbl_wr_addr_o = dp_wr_addr_i;
                tbl_wr_data_o = dp_wr_data_i;
            end

            case (state_q)
                ST_IDLE: begin
                    // clear_start beats any cfg request presented the same cycle
                    if (clear_start_i) begin
                        state_d   = ST_CLEAR;
                        clr_ptr_d = '0;
                    end else begin
                        cfg_req_ready_o = ~dp_wr_valid_i;
                        if (cfg_req_valid_i && !dp_wr_valid_i) begin
                            if (cfg_req_write_i) begin
                                tbl_wr_en_o   = 1'b1;
                                tbl_wr_addr_o = cfg_req_addr_i;
                                tbl_wr_data_o = cfg_req_wdata_i;
                                rsp_valid_d   = 1'b1;
                            end else begin
                                tbl_rd_en_o   = 1'b1;
                                tbl_rd_addr_o = cfg_req_addr_i;
                                state_d       = ST_RD_WAIT;
                            end
                        end
                    end
                end

                ST_RD_WAIT: begin
                    // Read data is registered into the response, giving a
                    // 2-cycle request-to-response latency.
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = tbl_rd_data_i;
                    state_d     = ST_IDLE;
                end

                ST_CLEAR: begin
                    if (!dp_wr_valid_i) begin
                        tbl_wr_en_o   = 1'b1;
                        tbl_wr_addr_o = clr_ptr_q;
                        tbl_wr_data_o = '0;
                        if (clr_ptr_q == CLR_LAST) begin
                            state_d   = ST_IDLE;
                            clr_ptr_d = '0;
                        end else begin
                            clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = (state_q == ST_CLEAR);
    assign cfg_rsp_valid_o = rsp_valid_q;
    assign cfg_rsp_rdata_o = rsp_rdata_q;

`ifdef MAU_RELIABLE_FLOWSTATE_CTRL_STATS_EN
    logic [31:0] stat_q, stat_d;
    logic        dp_defer;

    // A pending cfg write counts as deferred even though the datapath owns the
    // port regardless of what the cfg side asked for.
    assign dp_defer = dp_wr_valid_i &&
                      ((state_q == ST_CLEAR) ||
                       ((state_q == ST_IDLE) && cfg_req_valid_i && cfg_req_write_i));

    always_comb begin
        stat_d = stat_q;
        if (dp_defer && (stat_q != 32'hFFFF_FFFF)) begin
            stat_d = stat_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_dp_defer_o = stat_q;
`else
    assign stat_dp_defer_o = '0;
`endif

endmodule

// File: tb/tb_mau_reliable_flowstate_ctrl.sv
module tb_mau_reliable_flowstate_ctrl;

    localparam int FW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dp_wr_valid = 1'b0;
    logic [AW-1:0] dp_wr_addr = '0;
    logic [FW-1:0] dp_wr_data = '0;
    logic          cfg_req_valid = 1'b0;
    logic          cfg_req_ready;
    logic          cfg_req_write = 1'b0;
    logic [AW-1:0] cfg_req_addr = '0;
    logic [FW-1:0] cfg_req_wdata = '0;
    logic          cfg_rsp_valid;
    logic [FW-1:0] cfg_rsp_rdata;
    logic          clear_start = 1'b0;
    logic          busy;
    logic          tbl_wr_en;
    logic [AW-1:0] tbl_wr_addr;
    logic [FW-1:0] tbl_wr_data;
    logic          tbl_rd_en;
    logic [AW-1:0] tbl_rd_addr;
    logic [FW-1:0] tbl_rd_data = '0;
    logic [31:0]   stat_dp_defer;

    always #5 clk = ~clk;

    mau_reliable_flowstate_ctrl #(
        .FLOWSTATE_WIDTH(FW),
        .ADDR_WIDTH     (AW),
        .CLR_ON_RESET   (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dp_wr_valid_i  (dp_wr_valid),
        .dp_wr_addr_i   (dp_wr_addr),
        .dp_wr_data_i   (dp_wr_data),
        .cfg_req_valid_i(cfg_req_valid),
        .cfg_req_ready_o(cfg_req_ready),
        .cfg_req_write_i(cfg_req_write),
        .cfg_req_addr_i (cfg_req_addr),
        .cfg_req_wdata_i(cfg_req_wdata),
        .cfg_rsp_valid_o(cfg_rsp_valid),
        .cfg_rsp_rdata_o(cfg_rsp_rdata),
        .clear_start_i  (clear_start),
        .busy_o         (busy),
        .tbl_wr_en_o    (tbl_wr_en),
        .tbl_wr_addr_o  (tbl_wr_addr),
        .tbl_wr_data_o  (tbl_wr_data),
        .tbl_rd_en_o    (tbl_rd_en),
        .tbl_rd_addr_o  (tbl_rd_addr),
        .tbl_rd_data_i  (tbl_rd_data),
        .stat_dp_defer_o(stat_dp_defer)
    );

    // Flowstate RAM: synchronous write, 1-cycle registered read.
    logic [FW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
        if (tbl_rd_en) tbl_rd_data <= mem[tbl_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected cfg responses: data plus the cycle it must appear.
    typedef struct {
        logic [FW-1:0] data;
        int            due;
    } rsp_t;
    rsp_t sb_q[$];

    always @(negedge clk) begin
        rsp_t e;
        if (cfg_rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=valid data=%0h required=no response (cycle %0d)",
                         cfg_rsp_rdata, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", cfg_rsp_rdata, e.data);
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    // Reference model: table contents plus the controller's externally visible mode.
    logic [FW-1:0] ref_tbl [DEPTH];
    bit            clearing  = 1'b0;
    bit            rd_wait   = 1'b0;
    bit            rst_prev  = 1'b0;
    int            clr_done  = 0;      // sweep writes performed so far
    logic [31:0]   exp_stat  = '0;
    bit            cfg_pend  = 1'b0;
    bit            cfg_w     = 1'b0;
    logic [AW-1:0] cfg_a     = '0;
    logic [FW-1:0] cfg_d     = '0;

    // One clock cycle: drive at posedge+1, check at negedge, update the model.
    task automatic tick(input bit dpv, input logic [AW-1:0] dpa, input logic [FW-1:0] dpd,
                        input bit clr, input bit r);
        bit idle, ready_exp, acc, wr_exp;
        logic [AW-1:0] wa_exp;
        logic [FW-1:0] wd_exp;
        rsp_t e;
        rst           = r;
        dp_wr_valid   = dpv;
        dp_wr_addr    = dpa;
        dp_wr_data    = dpd;
        clear_start   = clr;
        cfg_req_valid = cfg_pend;
        cfg_req_write = cfg_w;
        cfg_req_addr  = cfg_a;
        cfg_req_wdata = cfg_d;
        @(negedge clk);
        if (r) begin
            if (rst_prev) begin
                chk("rst_rsp_valid", cfg_rsp_valid, 0);
                chk("rst_ready", cfg_req_ready, 0);
                chk("rst_wr_en", tbl_wr_en, 0);
                chk("rst_wr_addr", tbl_wr_addr, 0);
                chk("rst_wr_data", tbl_wr_data, 0);
                chk("rst_rd_en", tbl_rd_en, 0);
                chk("rst_rd_addr", tbl_rd_addr, 0);
                chk("rst_busy", busy, 1);
                chk("rst_stat", stat_dp_defer, 0);
            end
            // Responses due after the reset edge are dropped.
            while (sb_q.size() > 0 && sb_q[$].due > cyc) e = sb_q.pop_back();
            clearing = 1'b1;
            clr_done = 0;
            rd_wait  = 1'b0;
            exp_stat = '0;
        end else begin
            idle      = !clearing && !rd_wait;
            ready_exp = idle && !dpv && !clr;
            acc       = cfg_pend && ready_exp;
            chk("cfg_req_ready", cfg_req_ready, ready_exp);
            chk("busy", busy, clearing);
`ifdef MAU_RELIABLE_FLOWSTATE_CTRL_STATS_EN
            chk("stat_dp_defer", stat_dp_defer, exp_stat);
`else
            chk("stat_dp_defer", stat_dp_defer, 32'd0);
`endif
            wr_exp = 1'b0;
            wa_exp = '0;
            wd_exp = '0;
            if (dpv) begin
                wr_exp = 1'b1; wa_exp = dpa; wd_exp = dpd;
            end else if (clearing) begin
                wr_exp = 1'b1; wa_exp = AW'(clr_done); wd_exp = '0;
            end else if (acc && cfg_w) begin
                wr_exp = 1'b1; wa_exp = cfg_a; wd_exp = cfg_d;
            end
            chk("tbl_wr_en", tbl_wr_en, wr_exp);
            if (wr_exp) begin
                chk("tbl_wr_addr", tbl_wr_addr, wa_exp);
                chk("tbl_wr_data", tbl_wr_data, wd_exp);
            end
            chk("tbl_rd_en", tbl_rd_en, acc && !cfg_w);
            if (acc && !cfg_w) chk("tbl_rd_addr", tbl_rd_addr, cfg_a);

            if (dpv && (clearing || (idle && cfg_pend && cfg_w)) && exp_stat != 32'hFFFF_FFFF)
                exp_stat++;

            rd_wait = 1'b0;
            if (dpv) begin
                ref_tbl[dpa] = dpd;
            end else if (clearing) begin
                ref_tbl[clr_done] = '0;
                clr_done++;
                if (clr_done == DEPTH) clearing = 1'b0;
            end
            if (acc) begin
                e.data = cfg_w ? '0 : ref_tbl[cfg_a];
                e.due  = cyc + (cfg_w ? 1 : 2);
                sb_q.push_back(e);
                if (cfg_w) ref_tbl[cfg_a] = cfg_d;
                else       rd_wait = 1'b1;
                cfg_pend = 1'b0;
            end
            if (idle && clr) begin
                clearing = 1'b1;
                clr_done = 0;
            end
        end
        rst_prev = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic cfg_do(input bit w, input logic [AW-1:0] a, input logic [FW-1:0] d);
        cfg_pend = 1'b1; cfg_w = w; cfg_a = a; cfg_d = d;
        for (int i = 0; i < 60 && cfg_pend; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
        chk("cfg_accept_timeout", cfg_pend, 0);
        cfg_pend = 1'b0;
        idle_ticks(3);
    endtask

    initial begin
        bit            dpv, clr;
        logic [AW-1:0] dpa;
        logic [FW-1:0] dpd;
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 32'hDEAD_0000 + i;

        // 1: reset, then 16 sweep writes, busy drops in the 17th cycle
        @(posedge clk);
        #1;
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        idle_ticks(18);

        // 2: write then read back
        cfg_do(1'b1, 4'd5, 32'h1234);
        cfg_do(1'b0, 4'd5, '0);

        // 3: cfg write collides with a datapath write to the same address
        cfg_pend = 1'b1; cfg_w = 1'b1; cfg_a = 4'd7; cfg_d = 32'hAA;
        tick(1'b1, 4'd7, 32'h55, 1'b0, 1'b0);
        idle_ticks(3);
        cfg_do(1'b0, 4'd7, '0);

        // 4: clear sweep with three datapath stalls and an ignored restart
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        idle_ticks(5);
        tick(1'b1, 4'd2, 32'h22, 1'b0, 1'b0);
        idle_ticks(3);
        tick(1'b1, 4'd12, 32'hC12, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        tick(1'b1, 4'd3, 32'h33, 1'b0, 1'b0);
        idle_ticks(15);
        cfg_do(1'b0, 4'd2, '0);
        cfg_do(1'b0, 4'd12, '0);

        // 5: reset while a read is in flight
        cfg_pend = 1'b1; cfg_w = 1'b0; cfg_a = 4'd5; cfg_d = '0;
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        chk("rd_accepted_before_rst", cfg_pend, 0);
        cfg_pend = 1'b0;
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        idle_ticks(18);

        // 6: datapath holds the port while a cfg write waits
        cfg_pend = 1'b1; cfg_w = 1'b1; cfg_a = 4'd9; cfg_d = 32'h77;
        for (int i = 0; i < 8; i++) tick(1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom, 1'b0, 1'b0);
        chk("cfg_starved", cfg_pend, 1);
        for (int i = 0; i < 60 && cfg_pend; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
        chk("cfg_accept_timeout", cfg_pend, 0);
        cfg_pend = 1'b0;
        idle_ticks(3);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            if (!cfg_pend && $urandom_range(0, 1) == 1) begin
                cfg_pend = 1'b1;
                cfg_w    = 1'($urandom_range(0, 1));
                cfg_a    = AW'($urandom_range(0, DEPTH - 1));
                cfg_d    = $urandom;
            end
            dpv = ($urandom_range(0, 2) == 0);
            dpa = AW'($urandom_range(0, DEPTH - 1));
            dpd = $urandom;
            clr = ($urandom_range(0, 63) == 0);
            tick(dpv, dpa, dpd, clr, 1'b0);
        end
        for (int i = 0; i < 60 && cfg_pend; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
        chk("cfg_accept_timeout", cfg_pend, 0);
        cfg_pend = 1'b0;
        idle_ticks(25);
        for (int a = 0; a < DEPTH; a++) cfg_do(1'b0, AW'(a), '0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
